// File: rtl/acc_drain_array_if.sv
// acc_drain_array_if: control, accumulation input and drain bus signals of acc_drain_array
interface acc_drain_array_if #(
   parameter int CH   = 16,
   parameter int IN_W = 8
);
   localparam int CW = CH > 1 ? $clog2(CH) : 1;
   logic              start;
   logic [7:0]        num_pass;
   logic              mode;
   logic [4:0]        shift;
   logic              valid_i;
   logic [CH*IN_W-1:0] data_i;
   logic              bus_free;
   logic              valid_o;
   logic [31:0]       data_o;
   logic [CW-1:0]     ch_o;
   logic              busy;
   logic              conv_done;
   modport master (output start, num_pass, mode, shift, valid_i, data_i, bus_free,
                   input valid_o, data_o, ch_o, busy, conv_done);
   modport slave  (input start, num_pass, mode, shift, valid_i, data_i, bus_free,
                   output valid_o, data_o, ch_o, busy, conv_done);
endinterface

// File: rtl/acc_drain_array.sv
// acc_drain_array: multi-channel accumulation buffer drained channel by channel onto a 32-bit bus
module acc_drain_array #(
   parameter int CH     = 16,
   parameter int DEPTH  = 3136,
   parameter int IN_W   = 8,
   parameter int ACC_W  = 20,
   parameter int ADDR_W = 12
) (
   input logic clk,
   input logic rst_n,
   acc_drain_array_if.slave bus
);
   localparam int CW = CH > 1 ? $clog2(CH) : 1;
   typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
   state_t                  r_state;
   logic signed [ACC_W-1:0] r_mem [CH][DEPTH];
   logic [ADDR_W-1:0]       r_addr, r_rd_addr;
   logic [7:0]              r_pass, r_np;
   logic                    r_mode;
   logic [4:0]              r_shift;
   logic [CW-1:0]           r_ch, r_ch_o;
   logic [1:0]              r_k;
   logic                    r_last, r_valid_o, r_busy, r_done;
   logic [31:0]             r_data_o;
   logic signed [IN_W-1:0]  w_in [CH];
   logic signed [ACC_W:0]   w_sum [CH];
   logic signed [ACC_W-1:0] w_wr [CH];
   logic signed [ACC_W-1:0] w_rd, w_shr;
   logic [31:0]             w_raw;
   logic [7:0]              w_byte;
   logic                    w_acc_end, w_rd_end;

   assign bus.valid_o   = r_valid_o;
   assign bus.data_o    = r_data_o;
   assign bus.ch_o      = r_ch_o;
   assign bus.busy      = r_busy;
   assign bus.conv_done = r_done;

   // Per-channel update value: pass 0 loads the input, later passes add with saturation
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         w_in[c]  = bus.data_i[c*IN_W +: IN_W];
         w_sum[c] = (ACC_W+1)'(r_mem[c][r_addr]) + (ACC_W+1)'(w_in[c]);
         w_wr[c]  = r_pass == 8'd0 ? ACC_W'(w_in[c]) :
                    w_sum[c][ACC_W] != w_sum[c][ACC_W-1] ?
                    (w_sum[c][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
                    w_sum[c][ACC_W-1:0];
      end
   end

   // Drain read path: raw sign extension, or ReLU, shift and clamp to 127 for packed bytes
   always_comb begin
      w_acc_end = r_addr == ADDR_W'(DEPTH - 1);
      w_rd_end  = r_rd_addr == ADDR_W'(DEPTH - 1);
      w_rd      = r_mem[r_ch][r_rd_addr];
      w_raw     = 32'(w_rd);
      w_shr     = w_rd >>> r_shift;
      w_byte    = w_rd[ACC_W-1] ? 8'd0 : w_shr > ACC_W'(127) ? 8'd127 : w_shr[7:0];
   end

   // Buffer write; contents are deliberately left out of reset since pass 0 overwrites them
   always_ff @(posedge clk)
      if (r_state == ACC && bus.valid_i)
         for (int c = 0; c < CH; c++) r_mem[c][r_addr] <= w_wr[c];

   // Control FSM with registered outputs; drain reads only while no word is pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_rd_addr <= '0;
         r_pass    <= '0;
         r_np      <= '0;
         r_mode    <= 1'b0;
         r_shift   <= '0;
         r_ch      <= '0;
         r_ch_o    <= '0;
         r_k       <= '0;
         r_last    <= 1'b0;
         r_valid_o <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_data_o  <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_np      <= bus.num_pass == 8'd0 ? 8'd1 : bus.num_pass;
               r_mode    <= bus.mode;
               r_shift   <= bus.shift;
               r_addr    <= '0;
               r_pass    <= '0;
               r_rd_addr <= '0;
               r_ch      <= '0;
               r_k       <= '0;
               r_last    <= 1'b0;
               r_busy    <= 1'b1;
               r_state   <= ACC;
            end
            ACC: if (bus.valid_i) begin
               r_addr <= w_acc_end ? '0 : r_addr + 1'b1;
               if (w_acc_end) begin
                  if (r_pass == r_np - 8'd1) r_state <= DRAIN;
                  else r_pass <= r_pass + 8'd1;
               end
            end
            DRAIN: if (r_valid_o) begin
               if (bus.bus_free) begin
                  r_valid_o <= 1'b0;
                  if (r_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end else begin
               r_data_o  <= r_mode ? {w_byte, r_data_o[31:8]} : w_raw;
               r_valid_o <= !r_mode || r_k == 2'd3;
               r_k       <= r_k + 2'd1;
               r_ch_o    <= r_ch;
               r_rd_addr <= w_rd_end ? '0 : r_rd_addr + 1'b1;
               r_ch      <= r_ch + CW'(w_rd_end);
               r_last    <= w_rd_end && r_ch == CW'(CH - 1);
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_acc_drain_array.sv
// tb_acc_drain_array: randomized jobs checked against an array model of accumulate-then-drain
module tb_acc_drain_array;
   localparam int CH = 2, DEPTH = 8, IN_W = 8, ACC_W = 10, ADDR_W = 3;
   localparam int DW = CH * IN_W;
   localparam int AMAX = (1 << (ACC_W - 1)) - 1;
   localparam int AMIN = -(1 << (ACC_W - 1));
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0, n_chk = 0, n_fail = 0;
   int in_v [8][DEPTH][CH];
   logic [31:0] exp_d[$], got_d[$];
   int exp_c[$];

   acc_drain_array_if #(.CH(CH), .IN_W(IN_W)) bus ();
   acc_drain_array #(.CH(CH), .DEPTH(DEPTH), .IN_W(IN_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int x);
      return x > AMAX ? AMAX : x < AMIN ? AMIN : x;
   endfunction

   task automatic fill_rand();
      for (int p = 0; p < 8; p++)
         for (int a = 0; a < DEPTH; a++)
            for (int c = 0; c < CH; c++) in_v[p][a][c] = int'($urandom_range(255)) - 128;
   endtask

   task automatic fill_const(input int v);
      for (int p = 0; p < 8; p++)
         for (int a = 0; a < DEPTH; a++)
            for (int c = 0; c < CH; c++) in_v[p][a][c] = v;
   endtask

   task automatic build_exp(input int np, input bit md, input int sh);
      int m [CH][DEPTH];
      int v;
      logic [31:0] w;
      exp_d.delete();
      exp_c.delete();
      for (int p = 0; p < np; p++)
         for (int a = 0; a < DEPTH; a++)
            for (int c = 0; c < CH; c++) m[c][a] = p == 0 ? in_v[p][a][c] : sat(m[c][a] + in_v[p][a][c]);
      for (int c = 0; c < CH; c++)
         if (!md) begin
            for (int a = 0; a < DEPTH; a++) begin
               exp_d.push_back(32'(m[c][a]));
               exp_c.push_back(c);
            end
         end else begin
            for (int a = 0; a < DEPTH; a += 4) begin
               w = '0;
               for (int i = 0; i < 4; i++) begin
                  v = m[c][a+i] < 0 ? 0 : m[c][a+i] >>> sh;
                  if (v > 127) v = 127;
                  w[8*i +: 8] = v[7:0];
               end
               exp_d.push_back(w);
               exp_c.push_back(c);
            end
         end
   endtask

   task automatic run_job(input int np, input bit md, input int sh, input bit inj, input bit hold, input int abort);
      int npe, total, nw, b, widx, guard, last_p, prev, hcnt;
      bit seen, busy_low;
      npe = np == 0 ? 1 : np;
      total = npe * DEPTH;
      nw = md ? CH * DEPTH / 4 : CH * DEPTH;
      b = 0; widx = 0; guard = 0; last_p = 0; hcnt = 0; seen = 0; busy_low = 0;
      build_exp(npe, md, sh);
      got_d.delete();
      @(negedge clk);
      bus.start = 1'b1; bus.num_pass = 8'(np); bus.mode = md; bus.shift = 5'(sh);
      @(negedge clk);
      bus.start = 1'b0;
      while (b < total) begin
         bus.valid_i = $urandom_range(3) != 0;
         if (bus.valid_i) begin
            for (int c = 0; c < CH; c++) bus.data_i[c*IN_W +: IN_W] = 8'(in_v[b/DEPTH][b%DEPTH][c]);
            if (b == total - 1) last_p = cyc + 1;
            if (inj && b == DEPTH / 2) begin
               bus.start = 1'b1; bus.num_pass = 8'd7; bus.mode = ~md;
            end
            b++;
         end
         @(negedge clk);
         bus.start = 1'b0;
         if (!bus.busy) busy_low = 1'b1;
      end
      chk("busy_acc", 32'(busy_low), 32'd0);
      prev = last_p;
      while (widx < nw && guard < 2000) begin
         if (abort > 0 && widx == abort) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_valid", 32'(bus.valid_o), 32'd0);
            chk("rst_data", bus.data_o, 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_ch", 32'(bus.ch_o), 32'd0);
            #1 rst_n = 1'b1;
            return;
         end
         bus.valid_i = $urandom_range(1) != 0;
         bus.data_i = DW'($urandom);
         if (bus.valid_o) begin
            if (!seen) begin
               chk("latency", 32'(cyc - prev), md ? 32'd4 : 32'd1);
               seen = 1'b1;
            end
            if (hold && widx == 0 && hcnt < 10) begin
               bus.bus_free = 1'b0;
               chk("hold_data", bus.data_o, exp_d[0]);
               chk("hold_ch", 32'(bus.ch_o), 32'(exp_c[0]));
               hcnt++;
            end else begin
               bus.bus_free = $urandom_range(2) != 0;
               if (bus.bus_free) begin
                  chk("word_data", bus.data_o, exp_d[widx]);
                  chk("word_ch", 32'(bus.ch_o), 32'(exp_c[widx]));
                  got_d.push_back(bus.data_o);
                  widx++;
                  prev = cyc + 1;
                  seen = 1'b0;
               end
            end
         end else bus.bus_free = $urandom_range(1) != 0;
         @(negedge clk);
         guard++;
      end
      if (widx < nw) chk("drain_timeout", 32'(widx), 32'(nw));
      bus.bus_free = 1'b0;
      chk("done_pulse", 32'(bus.conv_done), 32'd1);
      chk("done_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("done_clear", 32'(bus.conv_done), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.num_pass = '0; bus.mode = 1'b0; bus.shift = '0;
      bus.valid_i = 1'b0; bus.data_i = '0; bus.bus_free = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_valid", 32'(bus.valid_o), 32'd0);
      chk("reset_data", bus.data_o, 32'd0);
      chk("reset_ch", 32'(bus.ch_o), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.conv_done), 32'd0);
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         in_v[0][a][0] = a;
         in_v[0][a][1] = -1 - a;
      end
      run_job(1, 1'b0, 0, 1'b0, 1'b0, 0);
      chk("ramp_count", 32'(got_d.size()), 32'd16);
      chk("ramp_w0", got_d[0], 32'h0000_0000);
      chk("ramp_w7", got_d[7], 32'h0000_0007);
      chk("ramp_w8", got_d[8], 32'hFFFF_FFFF);
      chk("ramp_w15", got_d[15], 32'hFFFF_FFF8);
      fill_const(-128);
      run_job(3, 1'b0, 0, 1'b0, 1'b0, 0);
      chk("neg_sum", got_d[5], 32'hFFFF_FE80);
      fill_const(127);
      run_job(5, 1'b0, 0, 1'b0, 1'b0, 0);
      chk("sat_pos", got_d[3], 32'h0000_01FF);
      fill_rand();
      in_v[0][0][0] = -5; in_v[0][1][0] = 10; in_v[0][2][0] = 100; in_v[0][3][0] = 2;
      for (int p = 1; p < 3; p++) begin
         in_v[p][0][0] = 0; in_v[p][1][0] = 0; in_v[p][2][0] = 100; in_v[p][3][0] = 0;
      end
      run_job(3, 1'b1, 1, 1'b0, 1'b0, 0);
      chk("pack_word", got_d[0], 32'h017F_0500);
      fill_rand();
      run_job(2, 1'b0, 0, 1'b0, 1'b1, 0);
      fill_rand();
      run_job(1, 1'b1, 3, 1'b0, 1'b1, 0);
      fill_rand();
      run_job(2, 1'b0, 0, 1'b0, 1'b0, 5);
      fill_const(3);
      run_job(1, 1'b0, 0, 1'b1, 1'b0, 0);
      chk("clean_job", got_d[15], 32'h0000_0003);
      repeat (8) begin
         fill_rand();
         run_job($urandom_range(4), 1'($urandom_range(1)), $urandom_range(7), 1'($urandom_range(1)), 1'b0, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
